// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states,
// the captured request record and the funct3 legality check.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] DMEM_ERR_RDATA = 32'h0;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  funct3;
        logic [31:0] wdata;
    } dmem_req_t;

    // Stores have no unsigned variants, so only the three size codes are legal.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return f3 inside {F3_B, F3_H, F3_W};
        else
            return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: extends a loaded byte/halfword/word and merges store data
// into an existing word, leaving unaddressed bytes untouched.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] store_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[{lane, 3'b000} +: 8];
        half_v = lane[1] ? word[31:16] : word[15:0];

        load_val = word;
        case (funct3)
            F3_B:    load_val = {{24{byte_v[7]}}, byte_v};
            F3_H:    load_val = {{16{half_v[15]}}, half_v};
            F3_BU:   load_val = {24'h0, byte_v};
            F3_HU:   load_val = {16'h0, half_v};
            default: load_val = word;
        endcase

        store_word = word;
        case (funct3[1:0])
            2'b00: store_word[{lane, 3'b000} +: 8] = wdata[7:0];
            2'b01: begin
                if (lane[1]) store_word[31:16] = wdata[15:0];
                else         store_word[15:0]  = wdata[15:0];
            end
            2'b10:   store_word = wdata;
            default: store_word = word;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed LATENCY, byte/half/word access.
// Define DMEM_MISALIGN_ERR_EN to reject misaligned halfword/word accesses instead of aligning them.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [31:0] mem [DEPTH_WORDS];

    state_t        state;
    dmem_req_t     req_q;
    logic [CW-1:0] cnt;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          range_err, f3_err, err, access_now;
    logic [31:0]   load_val, store_word;

    assign idx        = req_q.addr[AW+1:2];
    assign range_err  = req_q.addr[31:2] >= 30'(DEPTH_WORDS);
    assign f3_err     = !f3_legal(req_q.we, req_q.funct3);
    assign access_now = (state == ACCESS) && (cnt == '0);

    // Low bits are forced to the access size; with misalign errors enabled the
    // forced lane is irrelevant because such accesses never touch the array.
    always_comb begin
        lane = req_q.addr[1:0];
        case (req_q.funct3[1:0])
            2'b01:   lane = {req_q.addr[1], 1'b0};
            2'b10:   lane = 2'b00;
            default: lane = req_q.addr[1:0];
        endcase
    end

`ifdef DMEM_MISALIGN_ERR_EN
    logic misalign;
    assign misalign = (req_q.funct3[1:0] == 2'b01 && req_q.addr[0]) ||
                      (req_q.funct3[1:0] == 2'b10 && req_q.addr[1:0] != 2'b00);
    assign err = range_err || f3_err || misalign;
`else
    assign err = range_err || f3_err;
`endif

    dmem_lane_align u_align (
        .word       (mem[idx]),
        .lane       (lane),
        .funct3     (req_q.funct3),
        .wdata      (req_q.wdata),
        .load_val   (load_val),
        .store_word (store_word)
    );

    // Array is deliberately left out of reset; the write edge is the commit point.
    always_ff @(posedge clk) begin
        if (access_now && req_q.we && !err)
            mem[idx] <= store_word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= DMEM_ERR_RDATA;
            rsp_err   <= 1'b0;
            cnt       <= '0;
            req_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_q     <= '{we: req_we, addr: req_addr, funct3: req_funct3, wdata: req_wdata};
                        cnt       <= CW'(LATENCY - 1);
                        req_ready <= 1'b0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= err;
                        rsp_rdata <= (err || req_q.we) ? DMEM_ERR_RDATA : load_val;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 1 and 3) against a byte-array model.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int LAT0  = 1;
    localparam int LAT1  = 3;

    logic             clk;
    logic [1:0]       reset, req_valid, req_we, rsp_ready;
    logic [1:0][31:0] req_addr, req_wdata;
    logic [1:0][2:0]  req_funct3;
    logic [1:0]       req_ready, rsp_valid, rsp_err;
    logic [1:0][31:0] rsp_rdata;

    logic [7:0] bm [2][64];
    int n_cmp = 0;
    int n_err = 0;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT0)) u_dut0 (
        .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_funct3(req_funct3[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT1)) u_dut1 (
        .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_funct3(req_funct3[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: little-endian byte array, access size from funct3, errors from the rules.
    task automatic model(input int d, input logic we, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] wdata, output logic [31:0] rd, output logic er);
        int unsigned n, base;
        logic legal, mis;
        logic [31:0] v;
        n     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        mis   = (addr % n) != 0;
        er    = (addr >= DEPTH * 4) || !legal;
`ifdef DMEM_MISALIGN_ERR_EN
        er = er || mis;
`endif
        base = addr - (addr % n);
        rd   = 32'h0;
        if (!er) begin
            if (we) begin
                for (int i = 0; i < int'(n); i++) bm[d][base + i] = 8'(wdata >> (8 * i));
            end else begin
                v = 32'h0;
                for (int i = 0; i < int'(n); i++) v = v | (32'(bm[d][base + i]) << (8 * i));
                if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | ~((32'h1 << (8 * n)) - 1);
                rd = v;
            end
        end
    endtask

    task automatic xact(input int d, input logic we, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wdata, input int stall, output logic [31:0] rd);
        logic [31:0] exp_rd, hold;
        logic exp_er;
        int k;
        model(d, we, addr, f3, wdata, exp_rd, exp_er);
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
        req_funct3[d] = f3; req_wdata[d] = wdata; rsp_ready[d] = (stall == 0);
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        k = 1;
        while (!rsp_valid[d] && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("latency", 32'(k), 32'((d == 0 ? LAT0 : LAT1) + 1));
        chk("rsp_err", 32'(rsp_err[d]), 32'(exp_er));
        chk("rsp_rdata", rsp_rdata[d], exp_rd);
        rd = rsp_rdata[d];
        if (stall > 0) begin
            hold = rsp_rdata[d];
            for (int i = 0; i < stall; i++) begin
                if (i == 0) begin
                    req_valid[d] = 1'b1; req_we[d] = 1'b1; req_addr[d] = 32'h10;
                    req_funct3[d] = 3'b010; req_wdata[d] = 32'hA5A5A5A5;
                end
                @(negedge clk);
                req_valid[d] = 1'b0;
                chk("stall_valid", 32'(rsp_valid[d]), 32'd1);
                chk("stall_rdata", rsp_rdata[d], hold);
                chk("stall_req_ready", 32'(req_ready[d]), 32'd0);
            end
            rsp_ready[d] = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        chk("rsp_valid_drop", 32'(rsp_valid[d]), 32'd0);
        chk("req_ready_back", 32'(req_ready[d]), 32'd1);
    endtask

    initial begin
        logic [31:0] rd, a;
        logic [2:0] f3;
        logic we;
        int bad;
        reset = 2'b11; req_valid = '0; req_we = '0; req_addr = '0;
        req_funct3 = '0; req_wdata = '0; rsp_ready = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_req_ready", 32'(req_ready[d]), 32'd1);
            chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            chk("rst_rsp_rdata", rsp_rdata[d], 32'd0);
            chk("rst_rsp_err", 32'(rsp_err[d]), 32'd0);
        end
        reset = 2'b00;

        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 16; w++) xact(d, 1'b1, 32'(w * 4), 3'b010, $urandom, 0, rd);

        // Directed sequence on the LATENCY=1 instance.
        xact(0, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 0, rd); chk("tp_sw_rd", rd, 32'h0);
        xact(0, 1'b0, 32'h10, 3'b010, 32'h0, 0, rd);        chk("tp_lw1", rd, 32'hDEADBEEF);
        xact(0, 1'b1, 32'h11, 3'b000, 32'h000000AA, 0, rd);
        xact(0, 1'b0, 32'h10, 3'b010, 32'h0, 0, rd);        chk("tp_lw2", rd, 32'hDEADAAEF);
        xact(0, 1'b0, 32'h11, 3'b000, 32'h0, 0, rd);        chk("tp_lb", rd, 32'hFFFFFFAA);
        xact(0, 1'b0, 32'h11, 3'b100, 32'h0, 0, rd);        chk("tp_lbu", rd, 32'h000000AA);
        xact(0, 1'b1, 32'h12, 3'b001, 32'h00008001, 0, rd);
        xact(0, 1'b0, 32'h12, 3'b001, 32'h0, 0, rd);        chk("tp_lh", rd, 32'hFFFF8001);
        xact(0, 1'b0, 32'h12, 3'b101, 32'h0, 0, rd);        chk("tp_lhu", rd, 32'h00008001);
        xact(0, 1'b0, 32'h10, 3'b010, 32'h0, 0, rd);        chk("tp_lw3", rd, 32'h8001AAEF);
        xact(0, 1'b0, 32'h400, 3'b010, 32'h0, 0, rd);       chk("tp_range_rd", rd, 32'h0);
        xact(0, 1'b1, 32'h10, 3'b100, 32'h11223344, 0, rd);
        xact(0, 1'b0, 32'h10, 3'b010, 32'h0, 0, rd);        chk("tp_badst_keep", rd, 32'h8001AAEF);
        xact(0, 1'b0, 32'h13, 3'b010, 32'h0, 0, rd);
`ifdef DMEM_MISALIGN_ERR_EN
        chk("tp_misalign", rd, 32'h0);
`else
        chk("tp_misalign", rd, 32'h8001AAEF);
`endif
        // Back-pressure with an ignored request pulse, then confirm 0x10 untouched.
        xact(0, 1'b0, 32'h10, 3'b010, 32'h0, 5, rd);        chk("tp_stall_rd", rd, 32'h8001AAEF);
        xact(0, 1'b0, 32'h10, 3'b010, 32'h0, 0, rd);        chk("tp_pulse_ignored", rd, 32'h8001AAEF);

        // Reset during ACCESS of a store on the LATENCY=3 instance.
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h20;
        req_funct3[1] = 3'b010; req_wdata[1] = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        reset[1] = 1'b1;
        #1;
        chk("abort_req_ready", 32'(req_ready[1]), 32'd1);
        chk("abort_rsp_valid", 32'(rsp_valid[1]), 32'd0);
        chk("abort_rsp_rdata", rsp_rdata[1], 32'd0);
        chk("abort_rsp_err", 32'(rsp_err[1]), 32'd0);
        repeat (2) @(negedge clk);
        reset[1] = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid[1]) bad++;
        end
        chk("abort_no_rsp", 32'(bad), 32'd0);
        model(1, 1'b0, 32'h20, 3'b010, 32'h0, a, we);
        xact(1, 1'b0, 32'h20, 3'b010, 32'h0, 0, rd);
        chk("abort_old_data", rd, a);

        // Randomized traffic on both instances.
        for (int i = 0; i < 300; i++) begin
            int d;
            d  = i & 1;
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) < 8) a = 32'($urandom_range(0, 63));
            else if ($urandom_range(0, 1) == 0) a = 32'h400 + 32'($urandom_range(0, 4095));
            else a = $urandom | 32'h8000_0000;
            xact(d, we, a, f3, $urandom, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory end of the CPU load/store interface; the CPU core is the initiator.
- Accepts one request at a time over a valid/ready channel and performs byte, halfword or word loads and stores on an internal word array.
- Returns every request, loads and stores alike, over a valid/ready response channel with a fixed access latency.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the array; a power of two.
LATENCY, 1, cycles spent in ACCESS; must be ≥1.

Ports:
clk  input  1  clock; all state updates on its rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_funct3  input  3  RISC-V load/store funct3 (size and sign)
req_wdata  input  32  store data; the byte or halfword is taken from its low bits
rsp_valid  output  1  response present
rsp_ready  input  1  initiator accepts the response
rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors
rsp_err  output  1  request was rejected

Interface decision: one clock; reset is asynchronous and active-high; the clock port is clk and the reset port is reset.

Behaviour:
- Reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. Array contents are not reset.
- States: IDLE, ACCESS, RESP.
- req_ready = (state==IDLE). There is no request/response overlap.
- IDLE: on req_valid&&req_ready at edge T, capture we/addr/funct3/wdata and go to ACCESS with counter=LATENCY-1.
- ACCESS: decrement the counter each cycle. When counter==0, perform the access and go to RESP. rsp_valid rises at edge T+LATENCY.
- RESP: hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready. On the handshake edge go to IDLE and drive rsp_valid=0. Next acceptance is possible one cycle later, so throughput is one request per LATENCY+2 cycles minimum.
- Word index = addr[31:2]; lane = addr[1:0].
- Load funct3:
  - 000 LB: sign-extend byte at lane.
  - 001 LH: sign-extend halfword at lane[1].
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend halfword.
- Store funct3:
  - 000 SB: write wdata[7:0] to the byte lane only.
  - 001 SH: write wdata[15:0] to the halfword lane only.
  - 010 SW: write the full word.
  - Unaddressed bytes of the word are preserved.
- Error (rsp_err=1, rsp_rdata=0, no array write) when any of:
  - addr ≥ DEPTH_WORDS*4;
  - illegal funct3 (011/110/111 for loads; anything but 000/001/010 for stores);
  - misalignment, subject to the optional feature below.
- A store is committed exactly at the ACCESS→RESP edge. A load reads the array at that same edge, so a load after a store to the same address returns the new data.
- Reset mid-operation: return to IDLE immediately. A store already committed stays in the array; a store not yet committed is dropped. No response is issued.
- req_valid while not in IDLE is ignored: no acceptance and no state change.

Optional Feature:
Macro DMEM_MISALIGN_ERR_EN.
- Defined: a halfword access with addr[0]=1, or a word access with addr[1:0]≠0, returns rsp_err=1 and performs no write.
- Undefined: low address bits are forced to alignment (addr[0]=0 for halfword, addr[1:0]=0 for word), the access proceeds, and rsp_err reflects only range and funct3 errors.

Decomposition:
- Package dmem_pkg:
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state enum: IDLE, ACCESS, RESP;
  - DMEM_ERR_RDATA = 32'h0.
- One combinational sub-module, dmem_lane_align:
  - from a word, lane and funct3, produces the extended load value;
  - from a word, lane, funct3 and wdata, produces the merged store word;
  - reused for both paths.

Test Plan:
- SW addr 0x10, wdata 0xDEADBEEF, then LW 0x10 (LATENCY=1) → store response rsp_err=0 at T+1; load rdata=0xDEADBEEF.
- After the above, SB addr 0x11, wdata 0x000000AA; LW 0x10 → 0xDEADAAEF; LB 0x11 → 0xFFFFFFAA; LBU 0x11 → 0x000000AA.
- SH addr 0x12, wdata 0x00008001; LH 0x12 → 0xFFFF8001; LHU 0x12 → 0x00008001; LW 0x10 → 0x8001AAEF.
- LW addr 0x400 (DEPTH_WORDS=256) → rsp_err=1, rdata=0. Store with funct3=100 → rsp_err=1 and the array is unchanged. With the macro: LW 0x13 → rsp_err=1. Without the macro: LW 0x13 → word at 0x10.
- rsp_ready held low 5 cycles → rsp_valid/rdata stable, req_ready=0, and a req_valid pulse is ignored. Then rsp_ready=1 → IDLE, and req_ready=1 the following cycle.
- LATENCY=3: assert reset during ACCESS of SW 0x20 (0x12345678), then LW 0x20 → no response to the aborted request; outputs return to their reset values at once; the load returns the old contents.
